// File: rtl/hvac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hvac_pkg
//  Description : Shared types and default timing constants for the HVAC
//                zone scheduler (state encoding, run/slice/dead defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
package hvac_pkg;

    // Controller state: unit idle, heating a zone, cooling a zone, resting.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAT = 2'd1,
        ST_COOL = 2'd2,
        ST_DEAD = 2'd3
    } hvac_state_t;

    localparam int c_min_run_default   = 8;
    localparam int c_max_slice_default = 32;
    localparam int c_dead_time_default = 4;

endpackage : hvac_pkg
`default_nettype wire

// File: rtl/hvac_zone_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin search. Grants the first asserted
//                request at or after ptr, wrapping from N-1 back to 0.
//  Ports       : req   [N]      request vector
//                ptr   [PTR_W]  search start index (0..N-1)
//                grant [N]      one-hot grant, all-zero when nothing requests
//                valid          any request found
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             valid
);

    always_comb begin
        int                 w_sum;
        logic [PTR_W-1:0]   w_idx;
        grant = '0;
        valid = 1'b0;
        w_sum = 0;
        w_idx = '0;
        for (int j = 0; j < N; j++) begin
            // Index modulo N without a divider: ptr < N, so one subtract suffices.
            w_sum = int'(ptr) + j;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_idx = PTR_W'(w_sum);
            if (!valid && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                valid        = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/hvac_zone_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : hvac_zone_scheduler
//  Description : Shares one heat/cool unit among N_ZONES zones. Round-robin
//                grant, minimum run time, time-slice pre-emption and an
//                optional post-release dead time.
//  Ports       : clk, rst (async, active high)
//                heat_req/cool_req [N_ZONES]  per-zone level demand
//                damper [N_ZONES]             one-hot open damper of grant
//                heating, cooling             unit mode
//                lockout                      unit resting after release
//  Build macro : HVAC_SCHED_DEADTIME_EN - enables the DEAD rest phase; when
//                undefined a release returns straight to IDLE and lockout is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module hvac_zone_scheduler
    import hvac_pkg::*;
#(
    parameter int N_ZONES   = 4,
    parameter int MIN_RUN   = c_min_run_default,
    parameter int MAX_SLICE = c_max_slice_default,
    parameter int DEAD_TIME = c_dead_time_default
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_ZONES-1:0] heat_req,
    input  logic [N_ZONES-1:0] cool_req,
    output logic [N_ZONES-1:0] damper,
    output logic               heating,
    output logic               cooling,
    output logic               lockout
);

    localparam int c_zone_w = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
    localparam int c_run_w  = $clog2(MAX_SLICE + 1);
    localparam logic [c_run_w-1:0] c_min_run = c_run_w'(MIN_RUN);
    localparam logic [c_run_w-1:0] c_max_run = c_run_w'(MAX_SLICE);

    generate
        if (DEAD_TIME < 1 || MIN_RUN < 1 || MIN_RUN > MAX_SLICE) begin : g_param_check
            $error("hvac_zone_scheduler: invalid timing parameters");
        end
    endgenerate

    hvac_state_t          r_state, w_nxt_state;
    logic [c_zone_w-1:0]  r_ptr, w_nxt_ptr;
    logic [c_zone_w-1:0]  r_zone, w_nxt_zone;
    logic [c_run_w-1:0]   r_run, w_nxt_run;
    logic [N_ZONES-1:0]   r_damper, w_nxt_damper;
    logic                 r_heating, w_nxt_heating;
    logic                 r_cooling, w_nxt_cooling;

`ifdef HVAC_SCHED_DEADTIME_EN
    localparam int c_dead_w = $clog2(DEAD_TIME + 1);
    logic [c_dead_w-1:0]  r_dead, w_nxt_dead;
    logic                 r_lockout, w_nxt_lockout;
`endif

    // A zone requests only when exactly one of its demands is active.
    logic [N_ZONES-1:0]   w_req;
    logic [N_ZONES-1:0]   w_grant;
    logic                 w_valid;
    logic [c_zone_w-1:0]  w_grant_idx;
    logic                 w_keep;
    logic                 w_others;
    logic                 w_release;

    assign w_req = heat_req ^ cool_req;

    rr_arbiter #(
        .N     (N_ZONES),
        .PTR_W (c_zone_w)
    ) u_arb (
        .req   (w_req),
        .ptr   (r_ptr),
        .grant (w_grant),
        .valid (w_valid)
    );

    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < N_ZONES; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = c_zone_w'(i);
            end
        end
    end

    // Grant is kept while the zone still asks cleanly for the running mode.
    assign w_keep    = (r_state == ST_HEAT) ? (heat_req[r_zone] & ~cool_req[r_zone])
                                            : (cool_req[r_zone] & ~heat_req[r_zone]);
    // In HEAT/COOL the damper register is the one-hot of the granted zone.
    assign w_others  = |(w_req & ~r_damper);
    assign w_release = ((r_run >= c_min_run) & ~w_keep) |
                       ((r_run >= c_max_run) & w_others);

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_ptr     = r_ptr;
        w_nxt_zone    = r_zone;
        w_nxt_run     = r_run;
        w_nxt_damper  = r_damper;
        w_nxt_heating = r_heating;
        w_nxt_cooling = r_cooling;
`ifdef HVAC_SCHED_DEADTIME_EN
        w_nxt_dead    = r_dead;
        w_nxt_lockout = r_lockout;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_nxt_zone   = w_grant_idx;
                    w_nxt_run    = c_run_w'(1);
                    w_nxt_damper = w_grant;
                    if (heat_req[w_grant_idx]) begin
                        w_nxt_state   = ST_HEAT;
                        w_nxt_heating = 1'b1;
                    end else begin
                        w_nxt_state   = ST_COOL;
                        w_nxt_cooling = 1'b1;
                    end
                end
            end
            ST_HEAT, ST_COOL: begin
                if (w_release) begin
                    w_nxt_ptr     = (r_zone == c_zone_w'(N_ZONES - 1)) ? '0 : r_zone + 1'b1;
                    w_nxt_run     = '0;
                    w_nxt_damper  = '0;
                    w_nxt_heating = 1'b0;
                    w_nxt_cooling = 1'b0;
`ifdef HVAC_SCHED_DEADTIME_EN
                    w_nxt_state   = ST_DEAD;
                    w_nxt_lockout = 1'b1;
                    // Counts down to 0 so lockout spans exactly DEAD_TIME cycles.
                    w_nxt_dead    = c_dead_w'(DEAD_TIME - 1);
`else
                    w_nxt_state   = ST_IDLE;
`endif
                end else if (r_run != c_max_run) begin
                    w_nxt_run = r_run + 1'b1;
                end
            end
`ifdef HVAC_SCHED_DEADTIME_EN
            ST_DEAD: begin
                if (r_dead == '0) begin
                    w_nxt_state   = ST_IDLE;
                    w_nxt_lockout = 1'b0;
                end else begin
                    w_nxt_dead = r_dead - 1'b1;
                end
            end
`endif
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_zone    <= '0;
            r_run     <= '0;
            r_damper  <= '0;
            r_heating <= 1'b0;
            r_cooling <= 1'b0;
`ifdef HVAC_SCHED_DEADTIME_EN
            r_dead    <= '0;
            r_lockout <= 1'b0;
`endif
        end else begin
            r_state   <= w_nxt_state;
            r_ptr     <= w_nxt_ptr;
            r_zone    <= w_nxt_zone;
            r_run     <= w_nxt_run;
            r_damper  <= w_nxt_damper;
            r_heating <= w_nxt_heating;
            r_cooling <= w_nxt_cooling;
`ifdef HVAC_SCHED_DEADTIME_EN
            r_dead    <= w_nxt_dead;
            r_lockout <= w_nxt_lockout;
`endif
        end
    end

    assign damper  = r_damper;
    assign heating = r_heating;
    assign cooling = r_cooling;
`ifdef HVAC_SCHED_DEADTIME_EN
    assign lockout = r_lockout;
`else
    assign lockout = 1'b0;
`endif

endmodule : hvac_zone_scheduler
`default_nettype wire

// File: tb/tb_hvac_zone_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hvac_zone_scheduler
//  Description : Self-checking bench for hvac_zone_scheduler. A behavioural
//                model of the scheduling rules predicts every cycle's outputs.
//                Honours HVAC_SCHED_DEADTIME_EN to pick the dead-time length.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hvac_zone_scheduler;

    localparam int N    = 4;
    localparam int MINR = 8;
    localparam int MAXS = 32;
    localparam int DT   = 4;
`ifdef HVAC_SCHED_DEADTIME_EN
    localparam int DT_CYC = DT;
`else
    localparam int DT_CYC = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] heat_req = '0;
    logic [N-1:0] cool_req = '0;
    logic [N-1:0] damper;
    logic         heating;
    logic         cooling;
    logic         lockout;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: 0 idle, 1 heat, 2 cool, 3 rest
    int m_st, m_zone, m_run, m_ptr, m_dead;

    hvac_zone_scheduler #(
        .N_ZONES   (N),
        .MIN_RUN   (MINR),
        .MAX_SLICE (MAXS),
        .DEAD_TIME (DT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .heat_req (heat_req),
        .cool_req (cool_req),
        .damper   (damper),
        .heating  (heating),
        .cooling  (cooling),
        .lockout  (lockout)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_st = 0; m_zone = 0; m_run = 0; m_ptr = 0; m_dead = 0;
    endtask

    task automatic model_step(input logic [N-1:0] h, input logic [N-1:0] c);
        logic [N-1:0] r;
        bit want, others, rel;
        int k;
        r = h ^ c;
        if (m_st == 0) begin
            for (int j = 0; j < N; j++) begin
                k = (m_ptr + j) % N;
                if (r[k]) begin
                    m_st = h[k] ? 1 : 2;
                    m_zone = k;
                    m_run = 1;
                    break;
                end
            end
        end else if (m_st == 1 || m_st == 2) begin
            want = (m_st == 1) ? (h[m_zone] && !c[m_zone]) : (c[m_zone] && !h[m_zone]);
            others = 0;
            for (int j = 0; j < N; j++) if (j != m_zone && r[j]) others = 1;
            rel = (m_run >= MINR && !want) || (m_run >= MAXS && others);
            if (rel) begin
                m_ptr = (m_zone + 1) % N;
                m_run = 0;
                if (DT_CYC > 0) begin
                    m_st = 3;
                    m_dead = DT_CYC;
                end else begin
                    m_st = 0;
                end
            end else if (m_run < MAXS) begin
                m_run++;
            end
        end else begin
            m_dead--;
            if (m_dead == 0) m_st = 0;
        end
    endtask

    function automatic logic [N+2:0] model_out();
        logic [N-1:0] d;
        d = (m_st == 1 || m_st == 2) ? N'(1 << m_zone) : '0;
        return {d, m_st == 1, m_st == 2, m_st == 3};
    endfunction

    function automatic logic [N+2:0] obs();
        return {damper, heating, cooling, lockout};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(heat_req, cool_req);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        heat_req = '0;
        cool_req = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (obs() !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %b expected %b", obs(), 7'b0);
        end
        heat_req = 4'b1111;
        cool_req = 4'b0001;
        @(negedge clk); @(negedge clk); @(negedge clk);
        n_tests++;
        if (obs() !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got %b expected %b", obs(), 7'b0);
        end
        heat_req = '0;
        cool_req = '0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_heat();
        logic [N+2:0] e;
        do_reset();
        heat_req = 4'b0100;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 4) heat_req = '0;
            tick();
            e = model_out();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL single_heat cyc %0d: got %b expected %b", cyc, obs(), e);
            end
            if (cyc == 1 || cyc == 8) begin
                n_tests++;
                if ({damper, heating} !== 5'b0100_1) begin
                    n_fail++;
                    $display("FAIL single_heat_on cyc %0d: got %b expected %b", cyc, {damper, heating}, 5'b01001);
                end
            end
            if (cyc == 9) begin
                n_tests++;
                if ({damper, heating, lockout} !== {5'b0, DT_CYC > 0}) begin
                    n_fail++;
                    $display("FAIL single_heat_release: got %b expected %b", {damper, heating, lockout}, {5'b0, DT_CYC > 0});
                end
            end
            if (cyc == 9 + DT_CYC) begin
                n_tests++;
                if (lockout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_heat_lockout_end: got %b expected 0", lockout);
                end
            end
        end
    endtask

    task automatic test_slice();
        logic [N+2:0] e;
        do_reset();
        cool_req = 4'b0101;
        for (int cyc = 1; cyc <= 40 + DT_CYC; cyc++) begin
            tick();
            e = model_out();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL slice cyc %0d: got %b expected %b", cyc, obs(), e);
            end
            if (cyc == 32) begin
                n_tests++;
                if ({damper, cooling} !== 5'b0001_1) begin
                    n_fail++;
                    $display("FAIL slice_last_run: got %b expected %b", {damper, cooling}, 5'b00011);
                end
            end
            if (cyc == 33) begin
                n_tests++;
                if ({damper, cooling} !== 5'b0) begin
                    n_fail++;
                    $display("FAIL slice_preempt: got %b expected %b", {damper, cooling}, 5'b0);
                end
            end
            if (cyc == 34 + DT_CYC) begin
                n_tests++;
                if ({damper, cooling} !== 5'b0100_1) begin
                    n_fail++;
                    $display("FAIL slice_next_grant: got %b expected %b", {damper, cooling}, 5'b01001);
                end
            end
        end
    endtask

    task automatic test_conflict();
        do_reset();
        heat_req = 4'b0010;
        cool_req = 4'b0010;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            n_tests++;
            if (obs() !== '0) begin
                n_fail++;
                $display("FAIL conflict cyc %0d: got %b expected %b", cyc, obs(), 7'b0);
            end
        end
    endtask

    task automatic test_wrap();
        logic [N+2:0] e;
        int g;
        g = 10 + DT_CYC;
        do_reset();
        heat_req = 4'b0100;
        for (int cyc = 1; cyc <= g + 40 + DT_CYC; cyc++) begin
            if (cyc == 2) heat_req = 4'b1001;
            tick();
            e = model_out();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL wrap cyc %0d: got %b expected %b", cyc, obs(), e);
            end
            if (cyc == g) begin
                n_tests++;
                if (damper !== 4'b1000) begin
                    n_fail++;
                    $display("FAIL wrap_first: got %b expected %b", damper, 4'b1000);
                end
            end
            if (cyc == g + 33 + DT_CYC) begin
                n_tests++;
                if (damper !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL wrap_second: got %b expected %b", damper, 4'b0001);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [N+2:0] e;
        do_reset();
        cool_req = 4'b0010;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            tick();
            e = model_out();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL async_pre cyc %0d: got %b expected %b", cyc, obs(), e);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({damper, cooling} !== 5'b0) begin
            n_fail++;
            $display("FAIL async_midcycle: got %b expected %b", {damper, cooling}, 5'b0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_tests++;
        if ({damper, cooling, heating} !== 6'b0010_10) begin
            n_fail++;
            $display("FAIL async_regrant: got %b expected %b", {damper, cooling, heating}, 6'b001010);
        end
    endtask

    task automatic test_alternating();
        logic [N+2:0] e;
        logic         was_on;
        int           rel_cyc;
        int           last_grant;
        do_reset();
        heat_req = 4'b0011;
        was_on = 1'b0;
        rel_cyc = -1;
        last_grant = -1;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            tick();
            e = model_out();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL alternate cyc %0d: got %b expected %b", cyc, obs(), e);
            end
            if (was_on && !heating) rel_cyc = cyc;
            if (!was_on && heating && rel_cyc >= 0) begin
                n_tests++;
                if (cyc - rel_cyc !== DT_CYC + 1) begin
                    n_fail++;
                    $display("FAIL alternate_gap: got %0d expected %0d", cyc - rel_cyc, DT_CYC + 1);
                end
                n_tests++;
                if (int'(damper) === last_grant) begin
                    n_fail++;
                    $display("FAIL alternate_zone: got %b expected other than %0d", damper, last_grant);
                end
            end
            if (heating) last_grant = int'(damper);
            was_on = heating;
        end
    endtask

    task automatic test_random();
        logic [N+2:0] e;
        do_reset();
        for (int cyc = 1; cyc <= 1500; cyc++) begin
            if ($urandom_range(0, 5) == 0) begin
                heat_req = N'($urandom_range(0, 15));
                cool_req = N'($urandom_range(0, 15));
                if ($urandom_range(0, 2) != 0) cool_req = cool_req & ~heat_req;
            end
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                model_reset();
                @(negedge clk);
                rst = 1'b0;
            end else begin
                tick();
            end
            e = model_out();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b expected %b (h=%b c=%b)", cyc, obs(), e, heat_req, cool_req);
            end
            n_tests++;
            if ((heating && cooling) || ($onehot(damper) !== (heating || cooling))) begin
                n_fail++;
                $display("FAIL random_invariant cyc %0d: got d=%b h=%b c=%b expected exclusive one-hot", cyc, damper, heating, cooling);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_heat();
        test_slice();
        test_conflict();
        test_wrap();
        test_async_reset();
        test_alternating();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_hvac_zone_scheduler
`default_nettype wire
